pc_cmd_deframer: RTL

- Application-side consumer of the PC→FPGA command stream: drains 32-bit words from the xillybus write FIFO (first-word-fall-through) via pc_msg_valid/pc_msg/pc_msg_ack.
- Assembles each fixed 3-word message, classifies it as START, STOP or malformed, and presents it to the application datapath with a valid/ready handshake.
- Tracks the running state that drives app_running, and recovers from truncated messages with an inter-word timeout.

---
 rtl/pc_cmd_deframer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/pc_cmd_deframer.sv
`default_nettype none
// ============================================================================
// Module      : pc_cmd_deframer
// Description : Drains 3-word command messages from the xillybus PC->FPGA
//               FWFT FIFO, classifies each as START / STOP / malformed and
//               presents valid commands on a valid/ready handshake. Partial
//               messages are discarded after an inter-word timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_cmd_deframer #(
    parameter int XB_SIZE = 32,
    parameter int TIMEOUT = 1024,
    parameter int DELAY   = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               pc_msg_valid,
    input  logic [XB_SIZE-1:0] pc_msg,
    output logic               pc_msg_ack,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic               cmd_start,
    output logic [15:0]        cmd_n_pixels,
    output logic [15:0]        cmd_n_lines,
    output logic [31:0]        cmd_period,
    output logic               running,
    output logic               fmt_error,
    output logic               timeout_error,
    output logic [15:0]        cmd_count
);

    // Only a 32-bit stream is meaningful; DELAY has no effect in this RTL
    // (outputs are plain registers) and must simply be non-negative.
    if (XB_SIZE != 32 || DELAY < 0) begin : g_param_check
        $error("pc_cmd_deframer: XB_SIZE must be 32 and DELAY >= 0");
    end

    localparam int                 c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_W1    = 3'd1,
        S_W2    = 3'd2,
        S_CHECK = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rst_meta;
    logic                 r_rst_sync;
    logic                 w_rst_n;
    logic [XB_SIZE-1:0]   r_word0;
    logic [XB_SIZE-1:0]   r_word1;
    logic [XB_SIZE-1:0]   r_word2;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 w_ack;
    logic                 w_timeout;
    logic                 w_fmt_bad;
    logic                 w_is_stop;
    logic                 w_is_start;
    logic                 r_cmd_valid;
    logic                 r_cmd_start;
    logic [15:0]          r_n_pixels;
    logic [15:0]          r_n_lines;
    logic [31:0]          r_period;
    logic                 r_running;
    logic                 r_fmt_error;
    logic                 r_timeout_error;
    logic [15:0]          r_cmd_count;

    // Reset asserts asynchronously, releases two clocks after RESET rises.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rst_meta <= 1'b0;
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_sync <= r_rst_meta;
        end
    end

    assign w_rst_n = r_rst_sync;

    // Message classification from the three held words.
    assign w_is_stop  = (r_word0 == '0) && (r_word1 == '0) && (r_word2 == '0);
    assign w_is_start = (r_word0[31:16] == 16'h0000) && (r_word1[15:0] == 16'h0000) &&
                        (r_word0[15:0] != 16'h0000);

    // Next-state, FIFO pop and error detection.
    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_fmt_bad   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (pc_msg_valid && w_rst_n) begin
                    w_ack       = 1'b1;
                    w_state_nxt = S_W1;
                end
            end
            S_W1, S_W2: begin
                // A word arriving in the expiry cycle wins over the timeout.
                if (pc_msg_valid && w_rst_n) begin
                    w_ack       = 1'b1;
                    w_state_nxt = (r_state == S_W1) ? S_W2 : S_CHECK;
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHECK: begin
                if (w_is_stop || w_is_start) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_fmt_bad   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HOLD: begin
                if (cmd_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Word capture, timeout counter, command registers and status.
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_word0         <= '0;
            r_word1         <= '0;
            r_word2         <= '0;
            r_tmo_cnt       <= '0;
            r_cmd_valid     <= 1'b0;
            r_cmd_start     <= 1'b0;
            r_n_pixels      <= 16'h0000;
            r_n_lines       <= 16'h0000;
            r_period        <= 32'h0000_0000;
            r_running       <= 1'b0;
            r_fmt_error     <= 1'b0;
            r_timeout_error <= 1'b0;
            r_cmd_count     <= 16'h0000;
        end else begin
            r_fmt_error     <= w_fmt_bad;
            r_timeout_error <= w_timeout;

            if (w_ack) begin
                unique case (r_state)
                    S_IDLE:  r_word0 <= pc_msg;
                    S_W1:    r_word1 <= pc_msg;
                    S_W2:    r_word2 <= pc_msg;
                    default: ;
                endcase
            end

            // Counts idle cycles only while a message is partially held.
            if (w_ack || !((r_state == S_W1) || (r_state == S_W2))) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if ((r_state == S_CHECK) && !w_fmt_bad) begin
                r_cmd_valid <= 1'b1;
                r_cmd_start <= !w_is_stop;
                r_n_pixels  <= r_word0[15:0];
                r_n_lines   <= r_word1[31:16];
                r_period    <= r_word2[31:0];
            end

            if ((r_state == S_HOLD) && cmd_ready) begin
                r_cmd_valid <= 1'b0;
                r_running   <= r_cmd_start;
                r_cmd_count <= r_cmd_count + 16'd1;
            end
        end
    end

    assign pc_msg_ack    = w_ack;
    assign cmd_valid     = r_cmd_valid;
    assign cmd_start     = r_cmd_start;
    assign cmd_n_pixels  = r_n_pixels;
    assign cmd_n_lines   = r_n_lines;
    assign cmd_period    = r_period;
    assign running       = r_running;
    assign fmt_error     = r_fmt_error;
    assign timeout_error = r_timeout_error;
    assign cmd_count     = r_cmd_count;

endmodule
`default_nettype wire
